// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned REG_DEPTH = 32;
  localparam int unsigned REG_AW    = $clog2(REG_DEPTH);

  typedef logic [REG_AW-1:0]    regaddr_t;
  typedef logic [REG_WIDTH-1:0] regdata_t;

  localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set wins over clear.
module regfile_scoreboard #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NWRITE = 1,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         set,
  input  logic [AW-1:0]                set_sel,
  input  logic [NWRITE-1:0]            clr,
  input  logic [NWRITE-1:0][AW-1:0]    clr_sel,
  output logic [DEPTH-1:0]             busy_vec
);

  logic [DEPTH-1:0] busy_nxt;

  // Apply completing writes first, then a new claim so a fresh producer sticks.
  always_comb begin
    busy_nxt = busy_vec;
    for (int unsigned i = 0; i < NWRITE; i++) begin
      if (clr[i]) busy_nxt[clr_sel[i]] = 1'b0;
    end
    if (set) busy_nxt[set_sel] = 1'b1;
  end

  // Busy bit register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with optional write->read bypass and busy scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = REG_WIDTH,
  parameter int unsigned DEPTH    = REG_DEPTH,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NREAD-1:0][AW-1:0]       rsel,
  output logic [NREAD-1:0][WIDTH-1:0]    rdat,
  output logic [NREAD-1:0]               rbusy,
  input  logic [NWRITE-1:0]              wen,
  input  logic [NWRITE-1:0][AW-1:0]      wsel,
  input  logic [NWRITE-1:0][WIDTH-1:0]   wdat,
  input  logic                           claim,
  input  logic [AW-1:0]                  csel,
  output logic [DEPTH-1:0]               busy_vec
);

  logic [WIDTH-1:0]  regs [DEPTH];
  logic [NWRITE-1:0] wr_ok;
  logic              claim_ok;

  // Drop writes and claims aimed at a hard-wired zero register.
  always_comb begin
    wr_ok = '0;
    for (int unsigned i = 0; i < NWRITE; i++) begin
      wr_ok[i] = wen[i] && !((ZERO_REG != 0) && (wsel[i] == AW'(REG_ZERO)));
    end
    claim_ok = claim && !((ZERO_REG != 0) && (csel == AW'(REG_ZERO)));
  end

  // Storage; later ports overwrite earlier ones so the highest index wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      for (int unsigned i = 0; i < NWRITE; i++) begin
        if (wr_ok[i]) regs[wsel[i]] <= wdat[i];
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .set      (claim_ok),
    .set_sel  (csel),
    .clr      (wr_ok),
    .clr_sel  (wsel),
    .busy_vec (busy_vec)
  );

  // Read mux: stored value, optionally overridden by the winning same-cycle write.
  always_comb begin
    logic hit;
    hit   = 1'b0;
    rdat  = '0;
    rbusy = '0;
    for (int unsigned j = 0; j < NREAD; j++) begin
      hit      = 1'b0;
      rdat[j]  = regs[rsel[j]];
      rbusy[j] = busy_vec[rsel[j]];
      if ((BYPASS != 0) && !RST) begin
        for (int unsigned i = 0; i < NWRITE; i++) begin
          if (wr_ok[i] && (wsel[i] == rsel[j])) begin
            rdat[j] = wdat[i];
            hit     = 1'b1;
          end
        end
        if (hit) rbusy[j] = claim_ok && (csel == rsel[j]);
      end
      if ((ZERO_REG != 0) && (rsel[j] == AW'(REG_ZERO))) begin
        rdat[j]  = '0;
        rbusy[j] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed plus randomized bench for register_file_mp, one bypass and one non-bypass instance.
module tb_register_file_mp;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [NR-1:0][AW-1:0]   rsel;
  logic [NW-1:0]           wen;
  logic [NW-1:0][AW-1:0]   wsel;
  logic [NW-1:0][W-1:0]    wdat;
  logic                    claim;
  logic [AW-1:0]           csel;

  logic [NR-1:0][W-1:0]    rdat_b, rdat_n;
  logic [NR-1:0]           rbusy_b, rbusy_n;
  logic [D-1:0]            busy_b, busy_n;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference state: register contents and outstanding producers.
  logic [W-1:0] m_reg [D];
  logic [D-1:0] m_busy;

  always #5 CLK = ~CLK;

  register_file_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .BYPASS(1), .ZERO_REG(1)) dut_byp (
    .CLK(CLK), .RST(RST), .rsel(rsel), .rdat(rdat_b), .rbusy(rbusy_b),
    .wen(wen), .wsel(wsel), .wdat(wdat), .claim(claim), .csel(csel), .busy_vec(busy_b));

  register_file_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .BYPASS(0), .ZERO_REG(1)) dut_nob (
    .CLK(CLK), .RST(RST), .rsel(rsel), .rdat(rdat_n), .rbusy(rbusy_n),
    .wen(wen), .wsel(wsel), .wdat(wdat), .claim(claim), .csel(csel), .busy_vec(busy_n));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Highest-numbered enabled write port targeting addr that actually takes effect, or -1.
  function automatic int winner(input logic [AW-1:0] addr);
    winner = -1;
    if (addr == 0) return -1;
    for (int i = NW - 1; i >= 0; i--) begin
      if (wen[i] && wsel[i] == addr) return i;
    end
  endfunction

  task automatic check_reads();
    int w;
    logic [W-1:0] exp_d;
    logic exp_bz;
    for (int j = 0; j < NR; j++) begin
      // Non-bypass view: stored contents only.
      exp_d  = (rsel[j] == 0) ? '0 : m_reg[rsel[j]];
      exp_bz = (rsel[j] == 0) ? 1'b0 : m_busy[rsel[j]];
      check($sformatf("nob_rdat%0d r%0d", j, rsel[j]), rdat_n[j], exp_d);
      check($sformatf("nob_rbusy%0d r%0d", j, rsel[j]), 32'(rbusy_n[j]), 32'(exp_bz));
      // Bypass view: forwarded write data unless reset is active.
      w = winner(rsel[j]);
      if (!RST && w >= 0) begin
        exp_d  = wdat[w];
        exp_bz = claim && (csel == rsel[j]);
      end
      check($sformatf("byp_rdat%0d r%0d", j, rsel[j]), rdat_b[j], exp_d);
      check($sformatf("byp_rbusy%0d r%0d", j, rsel[j]), 32'(rbusy_b[j]), 32'(exp_bz));
    end
  endtask

  task automatic model_update();
    int w;
    if (RST) begin
      for (int k = 0; k < D; k++) m_reg[k] = '0;
      m_busy = '0;
      return;
    end
    for (int a = 1; a < D; a++) begin
      w = winner(AW'(a));
      if (w >= 0) begin
        m_reg[a]  = wdat[w];
        m_busy[a] = 1'b0;
      end
    end
    if (claim && csel != 0) m_busy[csel] = 1'b1;
  endtask

  // One clock: check combinational reads, advance, check registered busy bits.
  task automatic step();
    #1;
    check_reads();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    check("byp_busy_vec", busy_b, m_busy);
    check("nob_busy_vec", busy_n, m_busy);
  endtask

  task automatic idle();
    RST = 1'b0; wen = '0; wsel = '0; wdat = '0; claim = 1'b0; csel = '0;
  endtask

  initial begin
    for (int k = 0; k < D; k++) m_reg[k] = '0;
    m_busy = '0;
    idle();
    rsel = '0;
    @(negedge CLK);

    // Reset then sweep every register on both ports.
    RST = 1'b1;
    step();
    idle();
    for (int a = 0; a < D; a += 2) begin
      rsel[0] = AW'(a); rsel[1] = AW'(a + 1);
      step();
    end
    check("reset_busy_vec_zero", busy_b, 32'h0);

    // Write r5 and read it in the same and the next cycle.
    idle(); rsel[0] = 5'd5; rsel[1] = 5'd5;
    wen[0] = 1'b1; wsel[0] = 5'd5; wdat[0] = 32'hDEADBEEF;
    #1;
    check("same_cycle_bypass_r5", rdat_b[0], 32'hDEADBEEF);
    check("same_cycle_nobypass_r5", rdat_n[0], 32'h0);
    step();
    idle();
    step();
    check("next_cycle_r5", rdat_n[1], 32'hDEADBEEF);

    // Both ports write r7; the higher port wins.
    idle(); rsel[0] = 5'd7; rsel[1] = 5'd5;
    wen = 2'b11; wsel[0] = 5'd7; wsel[1] = 5'd7; wdat[0] = 32'h11; wdat[1] = 32'h22;
    step();
    idle();
    step();
    check("collision_r7", rdat_n[0], 32'h22);

    // Claim r9, then write clears it, then claim+write keeps it busy.
    idle(); rsel[0] = 5'd9; rsel[1] = 5'd9; claim = 1'b1; csel = 5'd9;
    step();
    idle();
    step();
    check("claim_r9_rbusy", 32'(rbusy_n[0]), 32'd1);
    wen[0] = 1'b1; wsel[0] = 5'd9; wdat[0] = 32'h5;
    step();
    idle();
    step();
    check("write_clears_r9", 32'(busy_b[9]), 32'd0);
    claim = 1'b1; csel = 5'd9; wen[1] = 1'b1; wsel[1] = 5'd9; wdat[1] = 32'h5;
    step();
    idle();
    step();
    check("claim_write_r9_busy", 32'(busy_b[9]), 32'd1);
    check("claim_write_r9_data", rdat_n[0], 32'h5);

    // Zero register ignores writes and claims.
    idle(); rsel[0] = 5'd0; rsel[1] = 5'd0;
    wen[0] = 1'b1; wsel[0] = 5'd0; wdat[0] = 32'hFFFF; claim = 1'b1; csel = 5'd0;
    step();
    idle();
    step();
    check("zero_reg_busy0", 32'(busy_b[0]), 32'd0);

    // Reset wipes state and drops a write issued in the reset cycle.
    idle(); rsel[0] = 5'd3; rsel[1] = 5'd4;
    claim = 1'b1; csel = 5'd3; wen[0] = 1'b1; wsel[0] = 5'd3; wdat[0] = 32'hAB;
    step();
    idle(); RST = 1'b1; wen[1] = 1'b1; wsel[1] = 5'd4; wdat[1] = 32'h1;
    step();
    idle();
    step();
    check("post_reset_r3", rdat_b[0], 32'h0);
    check("post_reset_r4", rdat_b[1], 32'h0);
    check("post_reset_busy_vec", busy_b, 32'h0);

    // Randomized traffic on a small address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      RST     = ($urandom_range(0, 39) == 0);
      wen     = 2'($urandom_range(0, 3));
      wsel[0] = 5'($urandom_range(0, 7));
      wsel[1] = 5'($urandom_range(0, 7));
      wdat[0] = $urandom;
      wdat[1] = $urandom;
      claim   = ($urandom_range(0, 2) == 0);
      csel    = 5'($urandom_range(0, 7));
      rsel[0] = 5'($urandom_range(0, 7));
      rsel[1] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
